value_window_monitor: RTL and testbench
=======================================

Name: value_window_monitor

Overview:
- Downstream consumer of the 32-bit up/down counter `value` output.
- Classifies each valid sample against a programmable [low, high] window and debounces excursions with a dwell count.
- Raises high/low alarms, sticky flags and an event count. Optionally flags counter wrap-around.
- Feeds status/interrupt logic; purely an observer, never back-pressures the counter.

Parameters:
WIDTH, 32, sample and threshold width
DWELL_W, 8, width of dwell threshold and dwell counter
CNT_W, 16, width of saturating alarm-event counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
valid_in  input  1  value_in is a new sample this cycle
value_in  input  WIDTH  counter value (unsigned)
low_thresh  input  WIDTH  window lower bound, inclusive, unsigned
high_thresh  input  WIDTH  window upper bound, inclusive, unsigned
dwell  input  DWELL_W  consecutive out-of-window samples needed to alarm; 0 treated as 1
clear  input  1  clears sticky flags and event counter
alarm_high  output  1  level, in ALARM_HIGH
alarm_low  output  1  level, in ALARM_LOW
alarm_pulse  output  1  one-cycle pulse on entry to either alarm state
sticky_high  output  1  set on ALARM_HIGH entry, held until clear
sticky_low  output  1  set on ALARM_LOW entry, held until clear
event_count  output  CNT_W  number of alarm entries, saturating
cfg_err  output  1  registered: low_thresh > high_thresh on last valid sample
wrap_pulse  output  1  one-cycle pulse on detected wrap (WRAP_DETECT_EN only, else tied 0)

Behaviour:
- Reset: every output 0. State is IN_WINDOW, dwell counter is 0, previous-sample register is 0 with its valid bit cleared.
- Timing: all outputs are registered. A sample presented with valid_in=1 at edge N is reflected in the outputs after edge N.
- valid_in=0: state, counters and flags hold; pulses deassert. clear still acts.
- Classification (unsigned):
  - ABOVE if value_in > high_thresh.
  - BELOW if value_in < low_thresh.
  - Otherwise INSIDE.
  - Thresholds and dwell are sampled on the same edge as the sample.
- cfg_err: if low_thresh > high_thresh, set cfg_err, force IN_WINDOW and clear the dwell counter. Sticky flags and event_count are unaffected.
- Let D = max(dwell, 1). States are IN_WINDOW, PEND_HIGH, PEND_LOW, ALARM_HIGH, ALARM_LOW.
  - IN_WINDOW + INSIDE: stay, cnt=0.
  - IN_WINDOW + ABOVE: if D=1 go to ALARM_HIGH; else PEND_HIGH, cnt=1. BELOW is symmetric.
  - PEND_HIGH + ABOVE: cnt+1; go to ALARM_HIGH when cnt+1 == D.
  - PEND_HIGH + INSIDE: IN_WINDOW, cnt=0.
  - PEND_HIGH + BELOW: restart as from IN_WINDOW+BELOW. PEND_LOW is symmetric.
  - ALARM_HIGH + ABOVE: stay.
  - ALARM_HIGH + INSIDE: IN_WINDOW, cnt=0, no exit dwell.
  - ALARM_HIGH + BELOW: restart as from IN_WINDOW+BELOW. ALARM_LOW is symmetric.
- Dwell counter saturates at its maximum and never wraps. A mid-run change of dwell to a value ≤ cnt alarms on the next out-of-window sample.
- Every transition into an ALARM state (including ALARM_HIGH directly to ALARM_LOW):
  - pulse alarm_pulse;
  - set the matching sticky flag;
  - increment event_count, saturating at all-ones.
- clear in the same cycle as an alarm entry: the sticky flag is set and event_count becomes 1. Set wins; the counter restarts at 1.
- Reset asserted mid-run: immediate return to reset values, independent of the clock.

Optional Feature:
- Macro: VALUE_WINDOW_MONITOR_WRAP_DETECT_EN.
- Defined:
  - Register the previous valid sample.
  - Pulse wrap_pulse for one cycle when prev=all-ones and cur=0 (up wrap), or prev=0 and cur=all-ones (down wrap).
  - No detection on the first valid sample after reset.
  - Wrap does not affect the FSM.
- Undefined: no previous-sample register; wrap_pulse tied 0.

Decomposition:
- Shared package value_mon_pkg holds:
  - state enum typedef (5 states, 3 bits);
  - classification enum (INSIDE/ABOVE/BELOW);
  - default widths.
- One natural sub-module: value_window_classify. It is combinational: value, low and high in; class and cfg_err out. It is reused by later monitors.
- FSM, counters and flags live in the top module.

Test Plan:
- Reset/idle: reset=0 mid-run with alarm_high=1 → all outputs 0 immediately; with reset=1, low=10, high=20, value=15 → IN_WINDOW, no pulses.
- Dwell high: low=10, high=20, dwell=3, values 21,22,23 → alarm_high=1 after the 3rd sample, alarm_pulse once, event_count=1, sticky_high=1.
- Dwell abort: dwell=3, values 25,26,15,25 → no alarm; cnt restarts at 1; valid_in=0 gaps between samples hold the count.
- Direct flip: in ALARM_HIGH with dwell=1, value=5 → alarm_low=1, alarm_high=0, event_count +1, both sticky flags set; clear in the same cycle → sticky_low=1, sticky_high=0, event_count=1.
- Config error: low=30, high=20, value=25 → cfg_err=1, state IN_WINDOW, no alarm. Saturation: preload 0xFFFF events plus one more alarm → event_count stays 0xFFFF.
- Wrap (macro defined): samples 0xFFFFFFFF then 0x00000000 → wrap_pulse one cycle; then 0x00000000 then 0xFFFFFFFF → pulse. Macro undefined → wrap_pulse=0 throughout.

Source files
------------

// File: rtl/value_mon_pkg.sv
// Shared types and default widths for the value window monitor family.
package value_mon_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DWELL_W_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IN_WINDOW  = 3'd0,
    ST_PEND_HIGH  = 3'd1,
    ST_PEND_LOW   = 3'd2,
    ST_ALARM_HIGH = 3'd3,
    ST_ALARM_LOW  = 3'd4
  } mon_state_e;

  typedef enum logic [1:0] {
    CLS_INSIDE = 2'd0,
    CLS_ABOVE  = 2'd1,
    CLS_BELOW  = 2'd2
  } mon_class_e;

endpackage

// File: rtl/value_window_classify.sv
// Combinational unsigned window classifier: compares a sample against an
// inclusive [low, high] window and flags an inverted window.
module value_window_classify
  import value_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [WIDTH-1:0] low_i,
  input  logic [WIDTH-1:0] high_i,
  output mon_class_e       class_o,
  output logic             cfg_err_o
);

  always_comb begin
    cfg_err_o = (low_i > high_i);
    if (value_i > high_i) begin
      class_o = CLS_ABOVE;
    end else if (value_i < low_i) begin
      class_o = CLS_BELOW;
    end else begin
      class_o = CLS_INSIDE;
    end
  end

endmodule

// File: rtl/value_window_monitor.sv
// Window monitor with dwell debounce, alarms, sticky flags and event count.
// Optional wrap-around detection: VALUE_WINDOW_MONITOR_WRAP_DETECT_EN.
module value_window_monitor
  import value_mon_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   value_in,
  input  logic [WIDTH-1:0]   low_thresh,
  input  logic [WIDTH-1:0]   high_thresh,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               clear,
  output logic               alarm_high,
  output logic               alarm_low,
  output logic               alarm_pulse,
  output logic               sticky_high,
  output logic               sticky_low,
  output logic [CNT_W-1:0]   event_count,
  output logic               cfg_err,
  output logic               wrap_pulse
);

  mon_state_e         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               sticky_high_q, sticky_high_d;
  logic               sticky_low_q, sticky_low_d;
  logic [CNT_W-1:0]   event_q, event_d;
  logic               cfg_err_q, cfg_err_d;

  mon_class_e         cls;
  logic               cls_cfg_err;
  logic [DWELL_W:0]   dwell_eff;
  logic [DWELL_W:0]   cnt_inc;
  logic [DWELL_W-1:0] cnt_sat;
  logic               enter_high, enter_low;

  value_window_classify #(.WIDTH(WIDTH)) u_classify (
    .value_i   (value_in),
    .low_i     (low_thresh),
    .high_i    (high_thresh),
    .class_o   (cls),
    .cfg_err_o (cls_cfg_err)
  );

  // Dwell of 0 behaves as 1; comparisons use one extra bit so a saturated
  // counter still compares correctly against any dwell value.
  assign dwell_eff = (dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell};
  assign cnt_inc   = {1'b0, cnt_q} + (DWELL_W+1)'(1);
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + DWELL_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pulse_d       = 1'b0;
    sticky_high_d = sticky_high_q;
    sticky_low_d  = sticky_low_q;
    event_d       = event_q;
    cfg_err_d     = cfg_err_q;

    if (clear) begin
      sticky_high_d = 1'b0;
      sticky_low_d  = 1'b0;
      event_d       = '0;
    end

    if (valid_in) begin
      cfg_err_d = cls_cfg_err;
      if (cls_cfg_err) begin
        state_d = ST_IN_WINDOW;
        cnt_d   = '0;
      end else begin
        case (cls)
          CLS_ABOVE: begin
            if (state_q == ST_PEND_HIGH) begin
              cnt_d   = cnt_sat;
              state_d = (cnt_inc >= dwell_eff) ? ST_ALARM_HIGH : ST_PEND_HIGH;
            end else if (state_q != ST_ALARM_HIGH) begin
              cnt_d   = DWELL_W'(1);
              state_d = (dwell_eff == (DWELL_W+1)'(1)) ? ST_ALARM_HIGH : ST_PEND_HIGH;
            end
          end
          CLS_BELOW: begin
            if (state_q == ST_PEND_LOW) begin
              cnt_d   = cnt_sat;
              state_d = (cnt_inc >= dwell_eff) ? ST_ALARM_LOW : ST_PEND_LOW;
            end else if (state_q != ST_ALARM_LOW) begin
              cnt_d   = DWELL_W'(1);
              state_d = (dwell_eff == (DWELL_W+1)'(1)) ? ST_ALARM_LOW : ST_PEND_LOW;
            end
          end
          default: begin
            state_d = ST_IN_WINDOW;
            cnt_d   = '0;
          end
        endcase
      end
    end

    enter_high = (state_d == ST_ALARM_HIGH) && (state_q != ST_ALARM_HIGH);
    enter_low  = (state_d == ST_ALARM_LOW)  && (state_q != ST_ALARM_LOW);

    // An alarm entry overrides a simultaneous clear: flag set, count restarts at 1.
    if (enter_high) sticky_high_d = 1'b1;
    if (enter_low)  sticky_low_d  = 1'b1;
    if (enter_high || enter_low) begin
      pulse_d = 1'b1;
      if (clear) begin
        event_d = CNT_W'(1);
      end else if (!(&event_q)) begin
        event_d = event_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IN_WINDOW;
      cnt_q         <= '0;
      pulse_q       <= 1'b0;
      sticky_high_q <= 1'b0;
      sticky_low_q  <= 1'b0;
      event_q       <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pulse_q       <= pulse_d;
      sticky_high_q <= sticky_high_d;
      sticky_low_q  <= sticky_low_d;
      event_q       <= event_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign alarm_high  = (state_q == ST_ALARM_HIGH);
  assign alarm_low   = (state_q == ST_ALARM_LOW);
  assign alarm_pulse = pulse_q;
  assign sticky_high = sticky_high_q;
  assign sticky_low  = sticky_low_q;
  assign event_count = event_q;
  assign cfg_err     = cfg_err_q;

`ifdef VALUE_WINDOW_MONITOR_WRAP_DETECT_EN
  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic             wrap_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (valid_in) begin
      prev_q     <= value_in;
      prev_vld_q <= 1'b1;
      wrap_q     <= prev_vld_q &&
                    (((&prev_q) && (value_in == '0)) ||
                     ((prev_q == '0) && (&value_in)));
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap_pulse = wrap_q;
`else
  assign wrap_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_value_window_monitor.sv
// Self-checking bench for value_window_monitor: scenario tasks with an
// expected-output queue, wrap expectations follow the build macro.
module tb_value_window_monitor;

`ifdef VALUE_WINDOW_MONITOR_WRAP_DETECT_EN
  localparam logic W = 1'b1;
`else
  localparam logic W = 1'b0;
`endif
  localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] value_in = '0;
  logic [31:0] low_thresh = '0;
  logic [31:0] high_thresh = '0;
  logic [7:0]  dwell = '0;
  logic        clear = 1'b0;
  logic        alarm_high, alarm_low, alarm_pulse, sticky_high, sticky_low;
  logic [15:0] event_count;
  logic        cfg_err, wrap_pulse;

  typedef struct {
    logic        v;
    logic [31:0] val;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [7:0]  dw;
    logic        clr;
    logic [22:0] exp;
  } step_t;

  logic [22:0] exp_q[$];
  step_t       plan[$];
  int          total = 0;
  int          bad = 0;
  logic [22:0] got, want;

  value_window_monitor dut (
    .clock       (clock),
    .reset       (reset),
    .valid_in    (valid_in),
    .value_in    (value_in),
    .low_thresh  (low_thresh),
    .high_thresh (high_thresh),
    .dwell       (dwell),
    .clear       (clear),
    .alarm_high  (alarm_high),
    .alarm_low   (alarm_low),
    .alarm_pulse (alarm_pulse),
    .sticky_high (sticky_high),
    .sticky_low  (sticky_low),
    .event_count (event_count),
    .cfg_err     (cfg_err),
    .wrap_pulse  (wrap_pulse)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  function automatic logic [22:0] pk(input logic ah, input logic al, input logic ap,
                                     input logic sh, input logic sl, input logic [15:0] ec,
                                     input logic ce, input logic wp);
    return {ah, al, ap, sh, sl, ec, ce, wp};
  endfunction

  function automatic logic [22:0] obs();
    return {alarm_high, alarm_low, alarm_pulse, sticky_high, sticky_low,
            event_count, cfg_err, wrap_pulse};
  endfunction

  function automatic step_t st(input logic v, input logic [31:0] val, input logic [31:0] lo,
                               input logic [31:0] hi, input logic [7:0] dw, input logic clr,
                               input logic [22:0] exp);
    step_t s;
    s.v = v; s.val = val; s.lo = lo; s.hi = hi; s.dw = dw; s.clr = clr; s.exp = exp;
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic apply_step(input step_t s);
    valid_in    = s.v;
    value_in    = s.val;
    low_thresh  = s.lo;
    high_thresh = s.hi;
    dwell       = s.dw;
    clear       = s.clr;
    exp_q.push_back(s.exp);
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (obs() !== 23'd0) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h", obs(), 23'd0);
    end
    reset = 1'b1;
    plan.delete();
    plan.push_back(st(1, 15, 10, 20, 3, 0, pk(0,0,0,0,0,16'd0,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_idle step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_dwell_high();
    plan.delete();
    plan.push_back(st(1, 20, 10, 20, 3, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 10, 10, 20, 3, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 21, 10, 20, 3, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 22, 10, 20, 3, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 23, 10, 20, 3, 0, pk(1,0,1,1,0,16'd1,0,0)));
    plan.push_back(st(0, 23, 10, 20, 3, 0, pk(1,0,0,1,0,16'd1,0,0)));
    plan.push_back(st(1, 15, 10, 20, 3, 0, pk(0,0,0,1,0,16'd1,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL dwell_high step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_dwell_abort();
    logic [31:0] vals[9] = '{25, 0, 26, 0, 15, 25, 0, 26, 27};
    logic        vlds[9] = '{1, 0, 1, 0, 1, 1, 0, 1, 1};
    plan.delete();
    for (int k = 0; k < 8; k++)
      plan.push_back(st(vlds[k], vals[k], 10, 20, 3, 0, pk(0,0,0,1,0,16'd1,0,0)));
    plan.push_back(st(vlds[8], vals[8], 10, 20, 3, 0, pk(1,0,1,1,0,16'd2,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL dwell_abort step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_direct_flip();
    plan.delete();
    plan.push_back(st(1, 5,  10, 20, 1, 0, pk(0,1,1,1,1,16'd3,0,0)));
    plan.push_back(st(1, 30, 10, 20, 1, 0, pk(1,0,1,1,1,16'd4,0,0)));
    plan.push_back(st(1, 5,  10, 20, 1, 1, pk(0,1,1,0,1,16'd1,0,0)));
    plan.push_back(st(1, 15, 10, 20, 1, 0, pk(0,0,0,0,1,16'd1,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL direct_flip step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_cfg_err();
    plan.delete();
    plan.push_back(st(1, 25, 10, 20, 3, 0, pk(0,0,0,0,1,16'd1,0,0)));
    plan.push_back(st(1, 25, 30, 20, 3, 0, pk(0,0,0,0,1,16'd1,1,0)));
    plan.push_back(st(0, 25, 10, 20, 3, 0, pk(0,0,0,0,1,16'd1,1,0)));
    plan.push_back(st(1, 25, 10, 20, 2, 0, pk(0,0,0,0,1,16'd1,0,0)));
    plan.push_back(st(1, 25, 10, 20, 2, 0, pk(1,0,1,1,1,16'd2,0,0)));
    plan.push_back(st(1, 25, 30, 20, 2, 0, pk(0,0,0,1,1,16'd2,1,0)));
    plan.push_back(st(1, 25, 10, 20, 2, 0, pk(0,0,0,1,1,16'd2,0,0)));
    plan.push_back(st(1, 26, 10, 20, 3, 0, pk(0,0,0,1,1,16'd2,0,0)));
    plan.push_back(st(1, 27, 10, 20, 2, 0, pk(1,0,1,1,1,16'd3,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL cfg_err step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_saturation();
    step_t s;
    s = st(0, 0, 10, 20, 0, 1, pk(1,0,0,0,0,16'd0,0,0));
    apply_step(s);
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL sat_clear got=%h want=%h", got, want); end
    // Alternating below/above with dwell 0 enters an alarm on every sample.
    valid_in = 1'b1; low_thresh = 10; high_thresh = 20; dwell = 0;
    for (int k = 0; k < 65535; k++) begin
      value_in = (k % 2 == 0) ? 32'd5 : 32'd30;
      @(posedge clock);
      #1;
    end
    valid_in = 1'b0;
    total++;
    if (obs() !== pk(0,1,1,1,1,16'hFFFF,0,0)) begin
      bad++; $display("FAIL sat_reach got=%h want=%h", obs(), pk(0,1,1,1,1,16'hFFFF,0,0));
    end
    plan.delete();
    plan.push_back(st(1, 30, 10, 20, 0, 0, pk(1,0,1,1,1,16'hFFFF,0,0)));
    plan.push_back(st(1, 31, 10, 20, 0, 0, pk(1,0,0,1,1,16'hFFFF,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL sat_hold step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_wrap();
    plan.delete();
    plan.push_back(st(1, MAXV, 0, MAXV, 1, 1, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 0,    0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,W)));
    plan.push_back(st(0, 0,    0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 0,    0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, MAXV, 0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,W)));
    plan.push_back(st(1, 7,    0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,0)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wrap step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    s = st(1, 30, 10, 20, 1, 0, pk(1,0,1,1,0,16'd1,0,0));
    apply_step(s);
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL pre_reset_alarm got=%h want=%h", got, want); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs() !== 23'd0) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs(), 23'd0);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    plan.delete();
    plan.push_back(st(1, MAXV, 0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,0)));
    plan.push_back(st(1, 0,    0, MAXV, 1, 0, pk(0,0,0,0,0,16'd0,0,W)));
    foreach (plan[i]) begin
      apply_step(plan[i]);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL post_reset step %0d got=%h want=%h", i, got, want); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_dwell_high();
    test_dwell_abort();
    test_direct_flip();
    test_cfg_err();
    test_saturation();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
